ysyx_23060240_isram_resp: RTL

YSYX_23060240_ISRAM_RESP -- requirements
Module: ysyx_23060240_isram_resp

---
 rtl/ysyx_23060240_pkg.sv | 26 ++
 rtl/ysyx_23060240_isram_array.sv | 30 +++
 rtl/ysyx_23060240_isram_resp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060240_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_23060240_pkg - shared types and constants for the instruction SRAM responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package ysyx_23060240_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } isram_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int unsigned LATENCY_MIN       = 1;
  localparam int unsigned LATENCY_MAX       = 15;

  // Out-of-range latencies are pinned to the nearest legal value so the 4-bit counter never wraps.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060240_isram_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_23060240_isram_array - word storage, one synchronous write port, one read port
// Revision: 1.0
// ---------------------------------------------------------------------------
module ysyx_23060240_isram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/ysyx_23060240_isram_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_23060240_isram_resp - fixed-latency instruction fetch responder over a word SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module ysyx_23060240_isram_resp
  import ysyx_23060240_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic                     resp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int unsigned IDX_W       = $clog2(DEPTH);
  localparam int unsigned LAT         = clamp_latency(LATENCY);
  localparam logic [3:0]  CNT_LOAD    = 4'(LAT - 1);
  localparam logic [31:0] DEPTH_W     = 32'(DEPTH);
  localparam bit          DIRECT_RESP = (LAT == 1);

  isram_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_ready_q, req_ready_d;
  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_data_q, resp_data_d;
  logic         resp_err_q, resp_err_d;

  logic             accept;
  logic [31:0]      look_addr;
  logic [31:0]      word_idx;
  logic             addr_err;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_data;

  assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid;

  // With single-cycle latency the RESP entry coincides with the accept, so look at the live address.
  assign look_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign word_idx  = (look_addr - BASE_ADDR) >> 2;
  assign addr_err  = (look_addr[1:0] != 2'b00) || (word_idx >= DEPTH_W);
  assign rd_idx    = word_idx[IDX_W-1:0];

  ysyx_23060240_isram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (DIRECT_RESP) begin
            state_d     = ST_RESP;
            resp_data_d = addr_err ? 32'h0 : rd_data;
            resp_err_d  = addr_err;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          resp_data_d = addr_err ? 32'h0 : rd_data;
          resp_err_d  = addr_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
